// File: rtl/weights_mem_ctrl.sv
// Port-A controller for the weights memory: arbitrates single-word loader writes
// against compute-engine burst reads and returns read data aligned to RD_LAT.
module weights_mem_ctrl #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] rd_len,
  output logic              rd_busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_done,
  output logic              mem_select,
  output logic [ADDR_W-1:0] mem_addr_1,
  output logic [ADDR_W-1:0] mem_addr_2,
  output logic              mem_wren_a,
  output logic [DATA_W-1:0] mem_data_a,
  input  logic [DATA_W-1:0] mem_q_a
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  typedef enum logic {GRANT_LD, GRANT_RD} grant_t;

  state_t              state, state_nxt;
  grant_t              last_grant;
  logic [ADDR_W-1:0]   rd_len_q;
  logic [ADDR_W-1:0]   rd_idx;
  logic [RD_LAT-1:0]   issue_pipe, pipe_nxt, in_flight;
  logic                grant_ld, grant_rd, rd_done_nxt;

  // The loader's address and data ride straight through; only the write enable is sequenced.
  assign mem_addr_1 = ld_addr;
  assign mem_data_a = ld_data;
  assign rd_valid   = issue_pipe[RD_LAT-1];
  assign rd_data    = rd_valid ? mem_q_a : '0;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_nxt   = state;
    grant_ld    = 1'b0;
    grant_rd    = 1'b0;
    pipe_nxt    = issue_pipe << 1;
    pipe_nxt[0] = (state == READ);
    unique case (state)
      IDLE: begin
        if (ld_req && (!rd_start || last_grant == GRANT_RD)) grant_ld = 1'b1;
        else if (rd_start)                                   grant_rd = 1'b1;
        if (grant_ld)      state_nxt = WRITE;
        else if (grant_rd) state_nxt = (rd_len == '0) ? DRAIN : READ;
      end
      WRITE: state_nxt = (ld_req && !rd_start) ? WRITE : IDLE;
      READ:  if (rd_idx == rd_len_q - ADDR_W'(1)) state_nxt = DRAIN;
      DRAIN: if (rd_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Done fires together with the final valid word: nothing else may still be in flight.
    in_flight           = pipe_nxt;
    in_flight[RD_LAT-1] = 1'b0;
    rd_done_nxt         = (state_nxt == DRAIN) && (in_flight == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_RD;
      rd_len_q   <= '0;
      rd_idx     <= '0;
      issue_pipe <= '0;
      ld_ack     <= 1'b0;
      rd_busy    <= 1'b0;
      rd_done    <= 1'b0;
      mem_select <= 1'b0;
      mem_wren_a <= 1'b0;
      mem_addr_2 <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop here samples pre-edge values.
      state      <= state_nxt;
      issue_pipe <= pipe_nxt;
      rd_done    <= rd_done_nxt;
      ld_ack     <= (state_nxt == WRITE);
      mem_wren_a <= (state_nxt == WRITE);
      mem_select <= (state_nxt == READ);
      rd_busy    <= (state_nxt == READ) || (state_nxt == DRAIN);
      if (grant_ld) last_grant <= GRANT_LD;
      if (grant_rd) begin
        last_grant <= GRANT_RD;
        rd_len_q   <= rd_len;
        rd_idx     <= '0;
        // A zero-length burst issues nothing, so the reader address is left alone.
        if (rd_len != '0) mem_addr_2 <= rd_base;
      end else if (state == READ && state_nxt == READ) begin
        rd_idx     <= rd_idx + ADDR_W'(1);
        mem_addr_2 <= mem_addr_2 + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_weights_mem_ctrl.sv
// Directed bench for weights_mem_ctrl with a behavioural port-A memory of latency RD_LAT.
module tb_weights_mem_ctrl;
  localparam int AW  = 13;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_req, rd_start;
  logic [AW-1:0] ld_addr, rd_base, rd_len;
  logic [DW-1:0] ld_data;
  logic          ld_ack, rd_busy, rd_valid, rd_done, mem_select, mem_wren_a;
  logic [DW-1:0] rd_data, mem_data_a, mem_q_a;
  logic [AW-1:0] mem_addr_1, mem_addr_2;

  int n_checks = 0;
  int n_pass   = 0;

  weights_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_data(rd_data), .rd_done(rd_done),
    .mem_select(mem_select), .mem_addr_1(mem_addr_1), .mem_addr_2(mem_addr_2),
    .mem_wren_a(mem_wren_a), .mem_data_a(mem_data_a), .mem_q_a(mem_q_a)
  );

  always #5 clk = ~clk;

  // Behavioural memory: address sampled at the edge, data out LAT cycles after it was presented.
  logic [DW-1:0] mem_model [0:(1<<AW)-1];
  logic [DW-1:0] q_pipe [LAT];
  logic [AW-1:0] mem_addr_mux;
  assign mem_addr_mux = mem_select ? mem_addr_2 : mem_addr_1;
  assign mem_q_a      = q_pipe[LAT-1];
  always @(posedge clk) begin
    if (mem_wren_a) mem_model[mem_addr_mux] <= mem_data_a;
    q_pipe[0] <= mem_model[mem_addr_mux];
    for (int i = 1; i < LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end

  // Per-run observations, cycle numbers relative to the first stimulus cycle.
  logic [AW-1:0] wa [8];
  logic [DW-1:0] wd [8];
  int            ack_cyc [$];
  logic [AW-1:0] ack_addr [$];
  logic [DW-1:0] ack_data [$];
  logic [AW-1:0] addr_q [$];
  logic [DW-1:0] data_q [$];
  int            done_cyc [$];
  int            first_addr_cyc, first_valid_cyc, busy_first, busy_last;
  int            ack_busy, bad_wr;
  bit            mix_timeout;

  task automatic apply_reset();
    rst = 1'b1; ld_req = 1'b0; rd_start = 1'b0;
    ld_addr = '0; ld_data = '0; rd_base = '0; rd_len = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives n_words loader writes from cycle 0 and, if rd_at >= 0, a burst request from cycle rd_at.
  task automatic run_mix(input int n_words, input int rd_at,
                         input logic [AW-1:0] base, input logic [AW-1:0] len);
    int w = 0;
    bit busy_seen = 0, over = 0, fin = 0;
    ack_cyc.delete(); ack_addr.delete(); ack_data.delete();
    addr_q.delete(); data_q.delete(); done_cyc.delete();
    first_addr_cyc = -1; first_valid_cyc = -1; busy_first = -1; busy_last = -1;
    ack_busy = 0; bad_wr = 0;
    for (int n = 0; n < 80 && !fin; n++) begin
      if (w < n_words) begin ld_req = 1'b1; ld_addr = wa[w]; ld_data = wd[w]; end
      else ld_req = 1'b0;
      if (n == rd_at) begin rd_start = 1'b1; rd_base = base; rd_len = len; end
      @(negedge clk);
      if (ld_ack) begin
        ack_cyc.push_back(n); ack_addr.push_back(mem_addr_1); ack_data.push_back(mem_data_a);
        if (!mem_wren_a || mem_select) bad_wr++;
        if (rd_busy) ack_busy++;
        w++;
        if (w >= n_words) ld_req = 1'b0;
      end else if (mem_wren_a) bad_wr++;
      if (mem_select) begin
        if (first_addr_cyc < 0) first_addr_cyc = n;
        addr_q.push_back(mem_addr_2);
      end
      if (rd_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = n;
        data_q.push_back(rd_data);
      end
      if (rd_done) done_cyc.push_back(n);
      if (rd_busy) begin
        if (!busy_seen) busy_first = n;
        busy_seen = 1; busy_last = n; rd_start = 1'b0;
      end else if (busy_seen) over = 1;
      @(posedge clk); #1;
      fin = (w >= n_words) && (rd_at < 0 || over);
    end
    mix_timeout = !fin;
    if (mix_timeout) begin ld_req = 1'b0; rd_start = 1'b0; end
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_req = 1'b0; rd_start = 1'b0;
    ld_addr = '0; ld_data = '0; rd_base = '0; rd_len = '0;
    @(negedge clk);
    n_checks++;
    if ({ld_ack, rd_busy, rd_valid, rd_done, mem_select, mem_wren_a} !== 6'b0)
      $display("FAIL reset_flags: got %b expected 000000",
               {ld_ack, rd_busy, rd_valid, rd_done, mem_select, mem_wren_a});
    else n_pass++;
    n_checks++;
    if (mem_addr_2 !== '0) $display("FAIL reset_addr2: got %h expected 0000", mem_addr_2);
    else n_pass++;
    n_checks++;
    if (rd_data !== '0) $display("FAIL reset_rd_data: got %h expected 0000", rd_data);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_write();
    wa[0] = 13'h0010; wd[0] = 16'hBEEF;
    run_mix(1, -1, '0, '0);
    n_checks++;
    if (mix_timeout || ack_cyc.size() != 1)
      $display("FAIL write_ack_count: got %0d timeout %0d expected 1", ack_cyc.size(), mix_timeout);
    else n_pass++;
    n_checks++;
    if (ack_cyc.size() < 1 || ack_cyc[0] != 1)
      $display("FAIL write_ack_cycle: got %p expected 1", ack_cyc);
    else n_pass++;
    n_checks++;
    if (ack_addr.size() < 1 || ack_addr[0] !== 13'h0010 || ack_data[0] !== 16'hBEEF)
      $display("FAIL write_addr_data: got %p/%p expected 0010/beef", ack_addr, ack_data);
    else n_pass++;
    n_checks++;
    if (bad_wr != 0) $display("FAIL write_wren_select: got %0d bad cycles expected 0", bad_wr);
    else n_pass++;
    n_checks++;
    if (mem_model[13'h0010] !== 16'hBEEF)
      $display("FAIL write_mem: got %h expected beef", mem_model[13'h0010]);
    else n_pass++;
  endtask

  task automatic test_burst();
    for (int i = 0; i < 4; i++) begin wa[i] = 13'h0010 + AW'(i); wd[i] = DW'(i); end
    run_mix(4, -1, '0, '0);
    n_checks++;
    if (ack_cyc.size() != 4 || ack_cyc[0] != 1 || ack_cyc[3] != 4)
      $display("FAIL stream_acks: got %p expected '{1,2,3,4}", ack_cyc);
    else n_pass++;
    run_mix(0, 0, 13'h0010, 13'd4);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ((i < addr_q.size() ? addr_q[i] : 'x) !== 13'h0010 + AW'(i))
        $display("FAIL burst_addr%0d: got %p expected %h", i, addr_q, 13'h0010 + AW'(i));
      else n_pass++;
      n_checks++;
      if ((i < data_q.size() ? data_q[i] : 'x) !== DW'(i))
        $display("FAIL burst_data%0d: got %p expected %0d", i, data_q, i);
      else n_pass++;
    end
    n_checks++;
    if (addr_q.size() != 4 || data_q.size() != 4)
      $display("FAIL burst_counts: got %0d addrs %0d words expected 4/4", addr_q.size(), data_q.size());
    else n_pass++;
    n_checks++;
    if (first_addr_cyc != 1 || first_valid_cyc != 1 + LAT)
      $display("FAIL burst_latency: got addr %0d valid %0d expected 1/%0d",
               first_addr_cyc, first_valid_cyc, 1 + LAT);
    else n_pass++;
    n_checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 4 + LAT)
      $display("FAIL burst_done: got %p expected '{%0d}", done_cyc, 4 + LAT);
    else n_pass++;
    n_checks++;
    if (mix_timeout || busy_first != 1 || busy_last != 4 + LAT)
      $display("FAIL burst_busy: got %0d..%0d expected 1..%0d", busy_first, busy_last, 4 + LAT);
    else n_pass++;
  endtask

  task automatic test_wrap();
    wa[0] = 13'h1FFE; wa[1] = 13'h1FFF; wa[2] = 13'h0000; wa[3] = 13'h0001;
    for (int i = 0; i < 4; i++) wd[i] = 16'hA000 + DW'(i);
    run_mix(4, -1, '0, '0);
    run_mix(0, 0, 13'h1FFE, 13'd4);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ((i < addr_q.size() ? addr_q[i] : 'x) !== wa[i])
        $display("FAIL wrap_addr%0d: got %p expected %h", i, addr_q, wa[i]);
      else n_pass++;
    end
    n_checks++;
    if (data_q.size() != 4 || data_q[0] !== 16'hA000 || data_q[2] !== 16'hA002 || data_q[3] !== 16'hA003)
      $display("FAIL wrap_data: got %p expected a000..a003", data_q);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    run_mix(0, 0, 13'h0500, 13'd0);
    n_checks++;
    if (mix_timeout || busy_first != 1 || busy_last != 1)
      $display("FAIL zero_busy: got %0d..%0d expected 1..1", busy_first, busy_last);
    else n_pass++;
    n_checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 1)
      $display("FAIL zero_done: got %p expected '{1}", done_cyc);
    else n_pass++;
    n_checks++;
    if (data_q.size() != 0 || addr_q.size() != 0)
      $display("FAIL zero_no_issue: got %0d words %0d addrs expected 0/0", data_q.size(), addr_q.size());
    else n_pass++;
    n_checks++;
    if (mem_addr_2 !== 13'h0001) $display("FAIL zero_addr_hold: got %h expected 0001", mem_addr_2);
    else n_pass++;
  endtask

  task automatic test_arbitration();
    apply_reset();
    wa[0] = 13'h0300; wd[0] = 16'h3000;
    run_mix(1, 0, 13'h0020, 13'd2);
    n_checks++;
    if (mix_timeout || ack_cyc.size() != 1 || ack_cyc[0] != 1 || busy_first != 3)
      $display("FAIL tie_from_reset: got ack %p busy %0d expected '{1}/3", ack_cyc, busy_first);
    else n_pass++;
    wa[0] = 13'h0301; wd[0] = 16'h3001;
    run_mix(1, 0, 13'h0020, 13'd2);
    n_checks++;
    if (mix_timeout || ack_cyc.size() != 1 || ack_cyc[0] != 1 || busy_first != 3)
      $display("FAIL tie_after_burst: got ack %p busy %0d expected '{1}/3", ack_cyc, busy_first);
    else n_pass++;
    wa[0] = 13'h0302; wd[0] = 16'h3002;
    run_mix(1, -1, '0, '0);
    wa[0] = 13'h0303; wd[0] = 16'h3003;
    run_mix(1, 0, 13'h0020, 13'd2);
    n_checks++;
    if (mix_timeout || busy_first != 1 || ack_cyc.size() != 1 || ack_cyc[0] != 2 + LAT + 2)
      $display("FAIL tie_after_write: got busy %0d ack %p expected 1/'{%0d}",
               busy_first, ack_cyc, 2 + LAT + 2);
    else n_pass++;
    n_checks++;
    if (ack_busy != 0 || bad_wr != 0)
      $display("FAIL ack_during_busy: got %0d acks while busy %0d bad writes expected 0/0", ack_busy, bad_wr);
    else n_pass++;
  endtask

  task automatic test_streaming_break();
    for (int i = 0; i < 4; i++) begin wa[i] = 13'h0100 + AW'(i); wd[i] = 16'h1111 * DW'(i + 1); end
    run_mix(4, 3, 13'h0040, 13'd1);
    n_checks++;
    if (mix_timeout || ack_cyc.size() != 4 || ack_cyc[0] != 1 || ack_cyc[1] != 2 ||
        ack_cyc[2] != 3 || ack_cyc[3] != 5 + LAT + 2)
      $display("FAIL stream_break_acks: got %p expected '{1,2,3,%0d}", ack_cyc, 5 + LAT + 2);
    else n_pass++;
    n_checks++;
    if (busy_first != 5) $display("FAIL stream_break_busy: got %0d expected 5", busy_first);
    else n_pass++;
    n_checks++;
    if (mem_model[13'h0101] !== 16'h2222 || mem_model[13'h0103] !== 16'h4444)
      $display("FAIL stream_break_mem: got %h/%h expected 2222/4444",
               mem_model[13'h0101], mem_model[13'h0103]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    bit hit = 0;
    int done_seen = 0;
    rd_base = 13'h0200; rd_len = 13'd8; rd_start = 1'b1;
    for (int n = 0; n < 40 && !hit; n++) begin
      @(negedge clk);
      if (rd_busy) rd_start = 1'b0;
      if (rd_done) done_seen++;
      if (mem_select && mem_addr_2 === 13'h0202) hit = 1;
    end
    n_checks++;
    if (!hit) $display("FAIL mid_reset_reach_word2: got no address 0202 expected it within 40 cycles");
    else n_pass++;
    rd_start = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({ld_ack, rd_busy, rd_valid, rd_done, mem_select, mem_wren_a} !== 6'b0 || mem_addr_2 !== '0)
      $display("FAIL mid_reset_clear: got %b addr %h expected 000000 addr 0000",
               {ld_ack, rd_busy, rd_valid, rd_done, mem_select, mem_wren_a}, mem_addr_2);
    else n_pass++;
    repeat (3) begin @(negedge clk); if (rd_done) done_seen++; end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin @(negedge clk); if (rd_done) done_seen++; end
    @(posedge clk); #1;
    n_checks++;
    if (done_seen != 0) $display("FAIL mid_reset_no_done: got %0d pulses expected 0", done_seen);
    else n_pass++;
    run_mix(0, 0, 13'h0010, 13'd4);
    n_checks++;
    if (mix_timeout || data_q.size() != 4 || data_q[1] !== 16'd1 || data_q[3] !== 16'd3 ||
        done_cyc.size() != 1 || done_cyc[0] != 4 + LAT)
      $display("FAIL mid_reset_next_burst: got %p done %p expected '{0,1,2,3} done '{%0d}",
               data_q, done_cyc, 4 + LAT);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_burst();
    test_wrap();
    test_zero_len();
    test_arbitration();
    test_streaming_break();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/weights_mem_ctrl.md
# weights_mem_ctrl

Controller that shares port A of the weights memory (via its select-muxed address inputs) between a weight loader (single-word writes) and the compute engine (sequential burst reads). It sequences the memory's write enable, data, address and select lines, returns read data with a valid strobe aligned to the memory's read latency, and arbitrates between the two requesters with alternating priority. Port B of the weights memory is not driven by this block.

## Interface
- ADDR_W, 13, weights memory address width
- DATA_W, 16, weights memory data width
- RD_LAT, 2, cycles from address presented on port A to mem_q_a valid (≥1)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ld_req  in  1  loader write request, held until ld_ack
- ld_addr  in  ADDR_W  loader write address
- ld_data  in  DATA_W  loader write data
- ld_ack  out  1  one-cycle pulse: current ld_addr/ld_data written this cycle
- rd_start  in  1  burst read request, held until rd_busy seen high
- rd_base  in  ADDR_W  burst start address, sampled at acceptance
- rd_len  in  ADDR_W  burst length in words, sampled at acceptance
- rd_busy  out  1  burst accepted and not yet complete
- rd_valid  out  1  rd_data holds a burst word this cycle
- rd_data  out  DATA_W  read word (mem_q_a passed through)
- rd_done  out  1  one-cycle pulse on the last rd_valid of a burst
- mem_select  out  1  0 = loader address (mem_addr_1), 1 = reader address (mem_addr_2)
- mem_addr_1  out  ADDR_W  loader address to memory
- mem_addr_2  out  ADDR_W  reader address to memory
- mem_wren_a  out  1  port A write enable
- mem_data_a  out  DATA_W  port A write data
- mem_q_a  in  DATA_W  port A read data

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: ld_req only → WRITE; rd_start only → READ; both → requester not granted last (last_grant reset = reader, so first tie goes to loader). Acceptance of rd_start latches rd_base, rd_len, clears index, sets rd_busy.
- WRITE (one cycle per word): mem_select=0, mem_addr_1=ld_addr, mem_data_a=ld_data, mem_wren_a=1, ld_ack=1. Next: stay in WRITE if ld_req high and rd_start low, else IDLE. Loader presents next word the cycle after ld_ack.
- READ: mem_select=1, mem_wren_a=0, mem_addr_2=(base+idx) mod 2^ADDR_W (wrap-around, no error); idx increments each cycle; after issuing idx=len-1 → DRAIN.
- rd_len=0: accepted, enters DRAIN directly with no issues; rd_done pulses next cycle, rd_valid never asserts.
- DRAIN: waits until issue pipeline empty, then rd_done with last rd_valid, rd_busy clears, → IDLE.
- Issue pipeline: RD_LAT-deep shift register of issue flags; rd_valid = its tail; rd_data = mem_q_a.
- mem_wren_a is 1 only in WRITE; loader never sees ld_ack while rd_busy.
- mem_addr_1/mem_data_a follow ld_addr/ld_data; mem_addr_2 holds last issued address outside READ.

## Timing
- Reset: state IDLE, last_grant=reader, all outputs 0 (ld_ack, rd_busy, rd_valid, rd_done, mem_select, mem_wren_a, mem_addr_2, rd_data cleared); issue pipeline cleared. Reset mid-burst aborts without rd_done; mid-write aborts without ld_ack.
- Write: ld_req high at edge k in IDLE → WRITE, mem_wren_a and ld_ack high cycle k+1. Streaming: one word/cycle.
- Read: rd_start at edge k → rd_busy and first address cycle k+1; word i address in cycle k+1+i, rd_valid for word i in cycle k+1+i+RD_LAT; rd_done with word len-1; rd_busy falls the cycle after rd_done; IDLE that cycle.
- Tie after a write streak ending in IDLE → reader wins; after a burst → loader wins.

## Test plan
- Reset then single write ld_addr=0x0010, ld_data=0xBEEF → ld_ack one cycle, mem_wren_a=1, mem_select=0, mem_addr_1=0x0010 same cycle.
- Burst rd_base=0x0010, rd_len=4, memory preloaded 0..3 → mem_addr_2 0x0010..0x0013 consecutive, 4 rd_valid starting RD_LAT cycles after first address, rd_done on 4th.
- Wrap: rd_base=0x1FFE, rd_len=4 → addresses 0x1FFE,0x1FFF,0x0000,0x0001.
- rd_len=0 → rd_busy one cycle, rd_done pulse, no rd_valid, no address change.
- ld_req and rd_start simultaneous from reset → write first, then burst; repeated ties alternate; streaming writes break to IDLE when rd_start rises.
- rst asserted mid-burst (word 2 of 8) → all outputs 0 immediately, no rd_done, next burst runs cleanly.
